// File: rtl/btb_update_gen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | btb_update_gen: turns up to two branch resolutions per cycle into BTB     |
// | write transactions, buffered in a small FIFO and issued one per cycle.    |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
`ifndef TypeBRANCH
`define TypeBRANCH 3'd1
`endif
`ifndef TypeJUMP
`define TypeJUMP 3'd2
`endif

module btb_update_gen #(
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = 32
) (
  input  logic              Clk,
  input  logic              Rest,
  output logic              BruReady,
  input  logic              Bru0Valid,
  input  logic [ADDR_W-1:0] Bru0Pc,
  input  logic [1:0]        Bru0HitBank,
  input  logic [2:0]        Bru0Type,
  input  logic [2:0]        Bru0PredType,
  input  logic              Bru0Taken,
  input  logic [ADDR_W-1:0] Bru0Target,
  input  logic [ADDR_W-1:0] Bru0PredTarget,
  input  logic [3:0]        Bru0OldCnt,
  input  logic              Bru1Valid,
  input  logic [ADDR_W-1:0] Bru1Pc,
  input  logic [1:0]        Bru1HitBank,
  input  logic [2:0]        Bru1Type,
  input  logic [2:0]        Bru1PredType,
  input  logic              Bru1Taken,
  input  logic [ADDR_W-1:0] Bru1Target,
  input  logic [ADDR_W-1:0] Bru1PredTarget,
  input  logic [3:0]        Bru1OldCnt,
  output logic              UpPcAble,
  output logic [1:0]        UpAbleBank,
  output logic [ADDR_W-1:0] UpPc,
  output logic              UpCntAble,
  output logic [3:0]        UpCnt,
  output logic              BtbUpTypeAble,
  output logic [2:0]        BtbUpType,
  output logic              BtbUpTagetAble,
  output logic [ADDR_W-1:0] BtbUpTaget
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [1:0]        bank;
    logic [ADDR_W-1:0] pc;
    logic              cntAble;
    logic [3:0]        cnt;
    logic              typeAble;
    logic [2:0]        typ;
    logic              tagetAble;
    logic [ADDR_W-1:0] target;
  } entry_t;

  function automatic entry_t buildEntry(
    input  logic [ADDR_W-1:0] pc,
    input  logic [1:0]        hitBank,
    input  logic [2:0]        typ,
    input  logic [2:0]        predType,
    input  logic              taken,
    input  logic [ADDR_W-1:0] target,
    input  logic [ADDR_W-1:0] predTarget,
    input  logic [3:0]        oldCnt,
    output logic              keep
  );
    entry_t     e;
    logic [1:0] bank;
    bank     = (hitBank == 2'b11) ? 2'b01 : hitBank;
    e.pc     = pc;
    e.typ    = typ;
    e.target = target;
    e.bank   = bank;
    if (bank == 2'b00) begin
      // A miss only matters if it was taken: allocate a fresh entry.
      e.cntAble   = 1'b1;
      e.typeAble  = 1'b1;
      e.tagetAble = 1'b1;
      e.cnt       = (typ == `TypeBRANCH) ? 4'b0001 : 4'b0000;
      keep        = taken;
    end else begin
      e.cntAble   = (typ == `TypeBRANCH);
      e.cnt       = {oldCnt[2:0], taken};
      e.typeAble  = (typ != predType);
      e.tagetAble = taken & (target != predTarget);
      keep        = e.cntAble | e.typeAble | e.tagetAble;
    end
    return e;
  endfunction

  entry_t          r_mem [FIFO_DEPTH];
  entry_t          r_out;
  logic            r_upValid;
  logic [PW-1:0]   r_wrPtr;
  logic [PW-1:0]   r_rdPtr;
  logic [CW-1:0]   r_count;

  entry_t          w_ent0;
  entry_t          w_ent1;
  logic            w_keep0;
  logic            w_keep1;
  logic            w_enq0;
  logic            w_enq1;
  logic            w_deq;
  logic [PW-1:0]   w_wrPtr1;

  assign BruReady = (r_count <= CW'(FIFO_DEPTH - 2));

  always_comb begin
    w_keep0 = 1'b0;
    w_keep1 = 1'b0;
    w_ent0  = buildEntry(Bru0Pc, Bru0HitBank, Bru0Type, Bru0PredType, Bru0Taken,
                         Bru0Target, Bru0PredTarget, Bru0OldCnt, w_keep0);
    w_ent1  = buildEntry(Bru1Pc, Bru1HitBank, Bru1Type, Bru1PredType, Bru1Taken,
                         Bru1Target, Bru1PredTarget, Bru1OldCnt, w_keep1);
  end

  assign w_enq0   = Bru0Valid & BruReady & w_keep0;
  assign w_enq1   = Bru1Valid & BruReady & w_keep1;
  assign w_deq    = (r_count != '0);
  // Port 1 lands in the first free slot when port 0 was filtered out.
  assign w_wrPtr1 = r_wrPtr + PW'(w_enq0);

  always_ff @(posedge Clk) begin
    if (w_enq0) r_mem[r_wrPtr]  <= w_ent0;
    if (w_enq1) r_mem[w_wrPtr1] <= w_ent1;
  end

  always_ff @(posedge Clk or negedge Rest) begin
    if (!Rest) begin
      r_wrPtr   <= '0;
      r_rdPtr   <= '0;
      r_count   <= '0;
      r_upValid <= 1'b0;
      r_out     <= '0;
    end else begin
      r_wrPtr <= r_wrPtr + PW'(w_enq0) + PW'(w_enq1);
      r_count <= r_count + CW'(w_enq0) + CW'(w_enq1) - CW'(w_deq);
      if (w_deq) begin
        r_out     <= r_mem[r_rdPtr];
        r_upValid <= 1'b1;
        r_rdPtr   <= r_rdPtr + 1'b1;
      end else begin
        r_out     <= '0;
        r_upValid <= 1'b0;
      end
    end
  end

  assign UpPcAble       = r_upValid;
  assign UpAbleBank     = r_out.bank;
  assign UpPc           = r_out.pc;
  assign UpCntAble      = r_out.cntAble;
  assign UpCnt          = r_out.cnt;
  assign BtbUpTypeAble  = r_out.typeAble;
  assign BtbUpType      = r_out.typ;
  assign BtbUpTagetAble = r_out.tagetAble;
  assign BtbUpTaget     = r_out.target;

endmodule

`default_nettype wire
